// File: rtl/updown_counter_pipe.sv
// Up/down counter with preset, programmable modulus, wrap/saturate mode,
// boundary pulse and a fixed-depth delayed copy of the count.
module updown_counter_pipe #(
    parameter int WIDTH       = 8,
    parameter int MAX_VALUE   = 2**WIDTH-1,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             preset,
    input  logic [WIDTH-1:0] presetdata,
    input  logic             updown,
    input  logic             saturate,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] counter_dly,
    output logic             bound_evt,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MAXW = MAXV[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic [WIDTH:0]   cnt_x, pre_x;
    logic [WIDTH-1:0] dly_q [PIPE_STAGES];

    // Next count and boundary flag; compares done one bit wider so a
    // modulus below 2**WIDTH never relies on natural overflow.
    always_comb begin
        cnt_x = {1'b0, cnt_q};
        pre_x = {1'b0, presetdata};
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (preset) begin
            cnt_d = (pre_x > MAXV) ? MAXW : presetdata;
        end else if (enable) begin
            if (updown) begin
                if (cnt_x >= MAXV) begin
                    evt_d = 1'b1;
                    cnt_d = saturate ? MAXW : '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    evt_d = 1'b1;
                    cnt_d = saturate ? '0 : MAXW;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and event registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    // Delay chain shifts every cycle; only reset clears it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dly_q <= '{default: '0};
        end else begin
            dly_q[0] <= cnt_q;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    assign counter     = cnt_q;
    assign counter_dly = dly_q[PIPE_STAGES-1];
    assign bound_evt   = evt_q;
    assign at_max      = (cnt_q == MAXW);
    assign at_min      = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter_pipe.sv
// Bench for updown_counter_pipe: table vectors, corner sequences and
// randomized stimulus against a reference model, on two parameter sets.
module tb_updown_counter_pipe;

    logic       clock = 1'b0;
    logic       reset_n, enable, preset, updown, saturate;
    logic [7:0] presetdata;

    logic [7:0] cnt_a, dly_a, cnt_b, dly_b;
    logic       evt_a, amax_a, amin_a, evt_b, amax_b, amin_b;

    int nchk = 0;
    int nerr = 0;

    int mx   [2] = '{255, 9};
    int pipe [2] = '{2, 3};
    int m_cnt[2];
    int m_evt[2];
    int hist [2][8];

    always #5 clock = ~clock;

    updown_counter_pipe #(.WIDTH(8)) u_a (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .preset(preset), .presetdata(presetdata),
        .updown(updown), .saturate(saturate),
        .counter(cnt_a), .counter_dly(dly_a), .bound_evt(evt_a),
        .at_max(amax_a), .at_min(amin_a)
    );

    updown_counter_pipe #(.WIDTH(8), .MAX_VALUE(9), .PIPE_STAGES(3)) u_b (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .preset(preset), .presetdata(presetdata),
        .updown(updown), .saturate(saturate),
        .counter(cnt_b), .counter_dly(dly_b), .bound_evt(evt_b),
        .at_max(amax_b), .at_min(amin_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit pr,
                         input int pd, input bit ud, input bit sat);
        reset_n    = r;
        enable     = en;
        preset     = pr;
        presetdata = 8'(pd);
        updown     = ud;
        saturate   = sat;
    endtask

    // Reference behaviour: plain integer arithmetic on the counting rules,
    // plus a history of past count values for the delayed copy.
    task automatic model_edge(input int i);
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = m_cnt[i];
        m_evt[i] = 0;
        if (!reset_n) begin
            m_cnt[i] = 0;
            for (int k = 0; k < 8; k++) hist[i][k] = 0;
        end else if (preset) begin
            m_cnt[i] = (int'(presetdata) > mx[i]) ? mx[i] : int'(presetdata);
        end else if (enable) begin
            if (updown) begin
                if (m_cnt[i] == mx[i]) begin
                    m_evt[i] = 1;
                    m_cnt[i] = saturate ? mx[i] : 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
                if (m_cnt[i] == 0) begin
                    m_evt[i] = 1;
                    m_cnt[i] = saturate ? 0 : mx[i];
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("a.counter", cnt_a, m_cnt[0]);
        chk("a.dly", dly_a, hist[0][pipe[0]-1]);
        chk("a.evt", evt_a, m_evt[0]);
        chk("a.at_max", amax_a, m_cnt[0] == mx[0]);
        chk("a.at_min", amin_a, m_cnt[0] == 0);
        chk("b.counter", cnt_b, m_cnt[1]);
        chk("b.dly", dly_b, hist[1][pipe[1]-1]);
        chk("b.evt", evt_b, m_evt[1]);
        chk("b.at_max", amax_b, m_cnt[1] == mx[1]);
        chk("b.at_min", amin_b, m_cnt[1] == 0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        check_model();
    endtask

    typedef struct {
        bit rst_n, en, pre;
        int pd;
        bit ud, sat;
        int ca;
        bit ea;
        int cb;
        bit eb;
    } vec_t;

    vec_t vec [18];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_evt[i] = 0;
            for (int k = 0; k < 8; k++) hist[i][k] = 0;
        end
        drive(0, 0, 0, 0, 1, 0);

        //        rst en pre  pd  ud sat   A  eA  B  eB
        vec[0]  = '{0, 0, 0,   0, 1, 0,    0, 0, 0, 0};
        vec[1]  = '{1, 1, 0,   0, 1, 0,    1, 0, 1, 0};
        vec[2]  = '{1, 1, 1, 200, 1, 1,  200, 0, 9, 0};
        vec[3]  = '{1, 1, 0,   0, 1, 1,  201, 0, 9, 1};
        vec[4]  = '{1, 1, 0,   0, 1, 1,  202, 0, 9, 1};
        vec[5]  = '{1, 1, 0,   0, 1, 1,  203, 0, 9, 1};
        vec[6]  = '{1, 1, 0,   0, 0, 0,  202, 0, 8, 0};
        vec[7]  = '{1, 0, 1,   3, 1, 0,    3, 0, 3, 0};
        vec[8]  = '{1, 1, 1,   5, 1, 0,    5, 0, 5, 0};
        vec[9]  = '{1, 1, 0,   0, 1, 0,    6, 0, 6, 0};
        vec[10] = '{1, 1, 0,   0, 0, 0,    5, 0, 5, 0};
        vec[11] = '{1, 0, 0,   0, 0, 0,    5, 0, 5, 0};
        vec[12] = '{0, 1, 1,  77, 1, 0,    0, 0, 0, 0};
        vec[13] = '{1, 1, 0,   0, 0, 0,  255, 1, 9, 1};
        vec[14] = '{1, 1, 0,   0, 0, 0,  254, 0, 8, 0};
        vec[15] = '{1, 0, 1, 255, 1, 0,  255, 0, 9, 0};
        vec[16] = '{1, 1, 0,   0, 1, 0,    0, 1, 0, 1};
        vec[17] = '{1, 1, 0,   0, 1, 1,    1, 0, 1, 0};

        for (int i = 0; i < 18; i++) begin
            drive(vec[i].rst_n, vec[i].en, vec[i].pre,
                  vec[i].pd, vec[i].ud, vec[i].sat);
            tick();
            chk($sformatf("vec%0d.a.counter", i), cnt_a, vec[i].ca);
            chk($sformatf("vec%0d.a.evt", i), evt_a, vec[i].ea);
            chk($sformatf("vec%0d.b.counter", i), cnt_b, vec[i].cb);
            chk($sformatf("vec%0d.b.evt", i), evt_b, vec[i].eb);
        end

        // Full up-count with wrap on the 8-bit modulus.
        drive(0, 0, 0, 0, 1, 0);
        tick();
        chk("wrap.reset_min", amin_a, 1);
        chk("wrap.reset_max", amax_a, 0);
        drive(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 255; i++) tick();
        chk("wrap.at255", cnt_a, 255);
        chk("wrap.max255", amax_a, 1);
        tick();
        chk("wrap.to0", cnt_a, 0);
        chk("wrap.evt", evt_a, 1);
        chk("wrap.dly", dly_a, 254);
        tick();
        chk("wrap.evt_drop", evt_a, 0);

        // Updown toggling around 4 never reaches a bound.
        drive(1, 0, 1, 4, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, (i % 2) == 0, 0);
            tick();
            chk($sformatf("tog%0d.a", i), cnt_a, (i % 2 == 0) ? 5 : 4);
            chk($sformatf("tog%0d.b", i), cnt_b, (i % 2 == 0) ? 5 : 4);
            chk($sformatf("tog%0d.evt", i), evt_a, 0);
        end

        // Reset mid-count, then the delayed copy stays zero for the depth.
        drive(1, 0, 1, 8'h37, 1, 0);
        tick();
        chk("mid.pre", cnt_a, 8'h37);
        drive(1, 1, 0, 0, 1, 0);
        tick();
        tick();
        drive(0, 1, 0, 0, 1, 0);
        tick();
        chk("mid.rst_cnt", cnt_a, 0);
        chk("mid.rst_evt", evt_a, 0);
        chk("mid.rst_dly", dly_a, 0);
        drive(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid.dly_b%0d", i), dly_b, 0);
        end
        tick();
        chk("mid.dly_b_track", dly_b, 1);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 64) != 0, ($urandom % 4) != 0,
                  ($urandom % 10) == 0,
                  ($urandom % 2) ? int'($urandom % 256) : int'($urandom % 12),
                  ($urandom % 3) != 0, $urandom % 2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
